dffsr_preset_ctrl: RTL and testbench
====================================

# dffsr_preset_ctrl

Sequencer that loads a WIDTH-bit bank of DFFSR cells asynchronously through their active-low set (S) and reset (R) pins instead of through D/CLK. Arbitrates between NREQ requesters, gates the bank clock off around each load, holds S/R low for the minimum pulse width, and re-enables the clock only after a recovery window. All S/R timing of the bank is therefore met by construction, in clock cycles. Sits beside a DFFSR register bank, between the bank's clock gate and its requesting agents.

## Interface
- WIDTH, 8: bits in the controlled DFFSR bank.
- NREQ, 2: number of requesters (>=2).
- PW_CYC, 2: cycles S/R are held low (>=1); must cover tminpwl of S and R.
- REC_CYC, 1: cycles after S/R release before clock re-enable (>=1); must cover S/R-to-CLK recovery.

- CLK  in  1  clock.
- R  in  1  reset, asynchronous, active-low.
- REQ  in  NREQ  per-requester load request, held high until GNT.
- VAL  in  NREQ*WIDTH  preset value, slice i belongs to REQ[i]; valid while REQ[i] high.
- GNT  out  NREQ  one-hot, one-cycle pulse: request accepted, VAL slice captured.
- DONE  out  NREQ  one-hot, one-cycle pulse: load for that requester complete.
- SN  out  WIDTH  drives bank S pins, active-low.
- RN  out  WIDTH  drives bank R pins, active-low.
- CKEN  out  1  bank clock-gate enable.
- BUSY  out  1  high in every state except IDLE.

## Operation
- All outputs are flops (no glitches on async pins). For every bit, SN[i] and RN[i] are never both low.
- States: CLR, GATE, PULSE, RECOV, IDLE.
- Reset (R low): state CLR, RN=all 0, SN=all 1, CKEN=0, GNT=DONE=0, BUSY=1, counter 0, RR pointer so REQ[0] has top priority. Takes effect immediately (async).
- CLR: after R release, held PW_CYC cycles, then RECOV. No DONE follows a CLR sequence.
- IDLE: SN=RN=all 1, CKEN=1. If any REQ high at the edge: winner chosen round-robin (priority starts at index after last winner), VAL slice latched, go to GATE.
- GATE (1 cycle): GNT[winner]=1, CKEN=0, SN=RN=all 1.
- PULSE (PW_CYC cycles): SN[i]=~v[i], RN[i]=v[i] for latched v; CKEN=0.
- RECOV (REC_CYC cycles): SN=RN=all 1, CKEN=0.
- RECOV exit: to IDLE with CKEN=1; DONE[winner]=1 in that first IDLE cycle (only if entered from PULSE).
- Requests arriving or changing while BUSY are ignored until IDLE; a requester dropping REQ before GNT is simply not served.
- Reset mid-operation: abort immediately into CLR; no GNT/DONE for the aborted load; RR pointer reset.

## Timing
- REQ sampled at edge 0 (in IDLE) -> GNT in cycle 1 -> PULSE cycles 2..1+PW_CYC -> RECOV next REC_CYC cycles -> DONE and CKEN=1 in cycle 2+PW_CYC+REC_CYC.
- Defaults: GNT cycle 1, S/R low cycles 2-3, RECOV cycle 4, DONE cycle 5.
- IDLE lasts at least 1 cycle between loads: back-to-back requests are served every 3+PW_CYC+REC_CYC cycles, and CKEN is high for at least one cycle in between.
- Counter width $clog2(max(PW_CYC,REC_CYC)+1); counts down, reload on state entry.

## Structure
- Package dffsr_ctrl_pkg: state enum (CLR, GATE, PULSE, RECOV, IDLE), default parameter constants.
- Sub-module rr_arb: NREQ-wide round-robin arbiter (req, advance, one-hot grant, pointer updated only on accept, async active-low reset).
- Top: FSM, counter, value latch, registered output stage.

## Test plan
- Reset: R low mid-PULSE -> RN=all 0, SN=all 1, CKEN=0 in the same cycle; after release, RN low 2 cycles, 1 RECOV cycle, then IDLE with CKEN=1 and no DONE.
- Single load: REQ[0]=1, VAL slice 0=8'hA5 -> GNT[0] cycle 1; cycles 2-3 SN=8'h5A, RN=8'hA5; DONE[0] cycle 5; CKEN low cycles 1-4.
- Contention: REQ=2'b11 held -> grants order 0,1,0,1; DONE after each; consecutive GNTs exactly 6 cycles apart.
- Late/withdrawn request: REQ[1] raised during BUSY and dropped before IDLE -> no GNT[1], BUSY falls, CKEN stays 1.
- Invariant, all runs: SN[i]&RN[i] never 0 for any bit; CKEN=0 whenever any SN/RN bit is low and for REC_CYC cycles after.
- Parameter sweep PW_CYC=1, REC_CYC=3, WIDTH=1, NREQ=3 -> DONE at cycle 6 after sample, round-robin over 3 requesters.

Source files
------------

// File: rtl/dffsr_preset_ctrl_pkg.sv
// Shared types and default parameters for the DFFSR preset sequencer.
package dffsr_preset_ctrl_pkg;

  typedef enum logic [2:0] {
    StClr,
    StGate,
    StPulse,
    StRecov,
    StIdle
  } state_e;

  localparam int unsigned DefWidth  = 8;
  localparam int unsigned DefNReq   = 2;
  localparam int unsigned DefPwCyc  = 2;
  localparam int unsigned DefRecCyc = 1;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dffsr_preset_ctrl_rr_arb.sv
// Round-robin arbiter; the priority pointer moves past the winner only on an accepted grant.
module dffsr_preset_ctrl_rr_arb #(
  parameter int unsigned NReq = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [NReq-1:0] req_i,
  input  logic            advance_i,
  output logic [NReq-1:0] gnt_o
);

  localparam int unsigned IdxW = $clog2(NReq);

  logic [IdxW-1:0] ptr_q, ptr_d;
  int unsigned     win_idx;
  logic            found;

  always_comb begin
    gnt_o   = '0;
    found   = 1'b0;
    win_idx = 0;
    // ptr_q holds the index with the highest priority this cycle.
    for (int unsigned off = 0; off < NReq; off++) begin
      if (!found && req_i[(32'(ptr_q) + off) % NReq]) begin
        found   = 1'b1;
        win_idx = (32'(ptr_q) + off) % NReq;
      end
    end
    if (found) gnt_o[win_idx] = 1'b1;
    ptr_d = ptr_q;
    if (advance_i && found) ptr_d = IdxW'((win_idx + 1) % NReq);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/dffsr_preset_ctrl.sv
// Loads a DFFSR bank through its async S/R pins with the bank clock gated off around each load.
module dffsr_preset_ctrl
  import dffsr_preset_ctrl_pkg::*;
#(
  parameter int unsigned Width  = DefWidth,
  parameter int unsigned NReq   = DefNReq,
  parameter int unsigned PwCyc  = DefPwCyc,
  parameter int unsigned RecCyc = DefRecCyc
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NReq-1:0]      req_i,
  input  logic [NReq*Width-1:0] val_i,
  output logic [NReq-1:0]      gnt_o,
  output logic [NReq-1:0]      done_o,
  output logic [Width-1:0]     sn_o,
  output logic [Width-1:0]     rn_o,
  output logic                 cken_o,
  output logic                 busy_o
);

  localparam int unsigned CntW = $clog2(max_u(PwCyc, RecCyc) + 1);
  localparam logic [CntW-1:0] PwLoad  = CntW'(PwCyc - 1);
  localparam logic [CntW-1:0] RecLoad = CntW'(RecCyc - 1);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [NReq-1:0]   win_q, win_d;
  logic [Width-1:0]  val_q, val_d, sel_val;
  logic              from_pulse_q, from_pulse_d;
  logic [NReq-1:0]   gnt_q, gnt_d, done_q, done_d, arb_gnt;
  logic [Width-1:0]  sn_q, sn_d, rn_q, rn_d;
  logic              cken_q, cken_d, busy_q, busy_d;
  logic              accept;

  // The DONE cycle does not sample requests, so IDLE spans two cycles between loads.
  assign accept = (state_q == StIdle) && (|req_i) && !(|done_q);

  dffsr_preset_ctrl_rr_arb #(
    .NReq(NReq)
  ) u_arb (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .req_i    (req_i),
    .advance_i(accept),
    .gnt_o    (arb_gnt)
  );

  always_comb begin
    sel_val = '0;
    for (int unsigned i = 0; i < NReq; i++) begin
      sel_val = sel_val | ({Width{arb_gnt[i]}} & val_i[i*Width +: Width]);
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    win_d        = win_q;
    val_d        = val_q;
    from_pulse_d = from_pulse_q;
    case (state_q)
      StClr: begin
        if (cnt_q == '0) begin
          state_d      = StRecov;
          cnt_d        = RecLoad;
          from_pulse_d = 1'b0;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StGate: begin
        state_d = StPulse;
        cnt_d   = PwLoad;
      end
      StPulse: begin
        if (cnt_q == '0) begin
          state_d      = StRecov;
          cnt_d        = RecLoad;
          from_pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StRecov: begin
        if (cnt_q == '0) state_d = StIdle;
        else             cnt_d   = cnt_q - CntW'(1);
      end
      StIdle: begin
        if (accept) begin
          state_d = StGate;
          win_d   = arb_gnt;
          val_d   = sel_val;
        end
      end
      default: state_d = StClr;
    endcase
  end

  // Outputs are decoded from the next state so every pin leaves a flop.
  always_comb begin
    gnt_d  = (state_d == StGate) ? win_d : '0;
    done_d = (state_q == StRecov && state_d == StIdle && from_pulse_q) ? win_q : '0;
    cken_d = (state_d == StIdle);
    busy_d = (state_d != StIdle);
    case (state_d)
      StClr: begin
        sn_d = '1;
        rn_d = '0;
      end
      StPulse: begin
        sn_d = ~val_d;
        rn_d = val_d;
      end
      default: begin
        sn_d = '1;
        rn_d = '1;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StClr;
      cnt_q        <= PwLoad;
      win_q        <= '0;
      val_q        <= '0;
      from_pulse_q <= 1'b0;
      gnt_q        <= '0;
      done_q       <= '0;
      sn_q         <= '1;
      rn_q         <= '0;
      cken_q       <= 1'b0;
      busy_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      win_q        <= win_d;
      val_q        <= val_d;
      from_pulse_q <= from_pulse_d;
      gnt_q        <= gnt_d;
      done_q       <= done_d;
      sn_q         <= sn_d;
      rn_q         <= rn_d;
      cken_q       <= cken_d;
      busy_q       <= busy_d;
    end
  end

  assign gnt_o  = gnt_q;
  assign done_o = done_q;
  assign sn_o   = sn_q;
  assign rn_o   = rn_q;
  assign cken_o = cken_q;
  assign busy_o = busy_q;

endmodule

// File: tb/tb_dffsr_preset_ctrl.sv
// Directed bench for dffsr_preset_ctrl: default instance plus a WIDTH=1/NREQ=3 sweep instance.
module tb_dffsr_preset_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req;
  logic [15:0] val;
  logic [1:0]  gnt, done;
  logic [7:0]  sn, rn;
  logic        cken, busy;

  logic [2:0]  req3, val3, gnt3, done3;
  logic [0:0]  sn3, rn3;
  logic        cken3, busy3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dffsr_preset_ctrl u_dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .val_i(val), .gnt_o(gnt),
    .done_o(done), .sn_o(sn), .rn_o(rn), .cken_o(cken), .busy_o(busy)
  );

  dffsr_preset_ctrl #(
    .Width(1), .NReq(3), .PwCyc(1), .RecCyc(3)
  ) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req3), .val_i(val3), .gnt_o(gnt3),
    .done_o(done3), .sn_o(sn3), .rn_o(rn3), .cken_o(cken3), .busy_o(busy3)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // S/R never both low; clock gated while any pin is low and for the recovery window after.
  int rl_main = 0;
  int rl_sw   = 0;
  always @(negedge clk) begin
    chk("inv_srn", sn | rn, 64'hFF);
    if (!(&(sn & rn))) begin
      chk("inv_cken_low", cken, 0);
      rl_main = 1;
    end else if (rl_main > 0) begin
      chk("inv_cken_rec", cken, 0);
      rl_main--;
    end
    chk("inv3_srn", sn3 | rn3, 1);
    if (!(sn3[0] & rn3[0])) begin
      chk("inv3_cken_low", cken3, 0);
      rl_sw = 3;
    end else if (rl_sw > 0) begin
      chk("inv3_cken_rec", cken3, 0);
      rl_sw--;
    end
  end

  task automatic clr_seq(input string tag);
    @(negedge clk); rst_n = 1'b1;
    #1 chk({tag, "_rn0"}, rn, 8'h00);
    @(negedge clk); chk({tag, "_rn1"}, rn, 8'h00);
    @(negedge clk); chk({tag, "_recov_rn"}, rn, 8'hFF); chk({tag, "_recov_cken"}, cken, 0);
    chk({tag, "_recov_busy"}, busy, 1);
    @(negedge clk); chk({tag, "_idle_cken"}, cken, 1); chk({tag, "_idle_busy"}, busy, 0);
    chk({tag, "_no_done"}, done, 2'b00);
  endtask

  int cyc, ng, nd, last_g, waited;
  logic [1:0] last_w;
  logic [2:0] last_w3;

  initial begin
    rst_n = 1'b1; req = '0; val = '0; req3 = '0; val3 = '0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_rn", rn, 8'h00); chk("rst_sn", sn, 8'hFF); chk("rst_cken", cken, 0);
    chk("rst_gnt", gnt, 2'b00); chk("rst_done", done, 2'b00); chk("rst_busy", busy, 1);
    clr_seq("init");

    // Single load from requester 0.
    req = 2'b01; val = 16'h00A5;
    @(negedge clk); chk("ld_gnt", gnt, 2'b01); chk("ld_c1_cken", cken, 0);
    chk("ld_c1_sn", sn, 8'hFF);
    req = 2'b00;
    @(negedge clk); chk("ld_c2_sn", sn, 8'h5A); chk("ld_c2_rn", rn, 8'hA5);
    @(negedge clk); chk("ld_c3_sn", sn, 8'h5A); chk("ld_c3_rn", rn, 8'hA5);
    chk("ld_c3_cken", cken, 0);
    @(negedge clk); chk("ld_c4_rn", rn, 8'hFF); chk("ld_c4_cken", cken, 0);
    chk("ld_c4_done", done, 2'b00);
    @(negedge clk); chk("ld_c5_done", done, 2'b01); chk("ld_c5_cken", cken, 1);
    chk("ld_c5_busy", busy, 0);
    @(negedge clk); chk("ld_c6_done", done, 2'b00);

    // Reset in the middle of a PULSE.
    req = 2'b10; val = 16'h0F00;
    @(negedge clk); chk("ab_gnt", gnt, 2'b10);
    req = 2'b00;
    @(negedge clk); chk("ab_rn", rn, 8'h0F);
    #2 rst_n = 1'b0;
    #1 chk("ab_rst_rn", rn, 8'h00); chk("ab_rst_sn", sn, 8'hFF); chk("ab_rst_cken", cken, 0);
    chk("ab_rst_busy", busy, 1);
    clr_seq("ab");

    // Contention from a fresh pointer: 0,1,0,1, GNTs 6 cycles apart.
    req = 2'b11; val = 16'hC33C;
    cyc = 0; ng = 0; nd = 0; last_g = 0; last_w = '0;
    while ((ng < 4 || nd < 4) && cyc < 60) begin
      @(negedge clk); cyc++;
      if (gnt != 2'b00) begin
        chk("ct_gnt", gnt, (ng % 2 == 0) ? 2'b01 : 2'b10);
        if (ng > 0) chk("ct_gap", cyc - last_g, 6);
        last_g = cyc; last_w = gnt; ng++;
        if (ng == 4) req = 2'b00;
      end
      if (ng > 0 && cyc == last_g + 1) chk("ct_rn", rn, last_w[0] ? 8'h3C : 8'hC3);
      if (done != 2'b00) begin
        chk("ct_done", done, last_w); chk("ct_done_lat", cyc - last_g, 4); nd++;
      end
    end
    chk("ct_ngnt", ng, 4); chk("ct_ndone", nd, 4);

    // Request raised while busy and withdrawn before IDLE is never served.
    req = 2'b01; val = 16'h0081;
    waited = 0;
    while (gnt == 2'b00 && waited < 10) begin
      @(negedge clk); waited++;
    end
    chk("lt_gnt", gnt, 2'b01);
    req = 2'b00;
    @(negedge clk); req = 2'b10;
    @(negedge clk);
    @(negedge clk); chk("lt_c4_cken", cken, 0); req = 2'b00;
    @(negedge clk); chk("lt_done", done, 2'b01); chk("lt_busy", busy, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("lt_nognt", gnt, 2'b00); chk("lt_idle_busy", busy, 0); chk("lt_cken", cken, 1);
    end

    // Sweep instance: PW=1, REC=3, three requesters.
    req3 = 3'b111; val3 = 3'b101;
    cyc = 0; ng = 0; nd = 0; last_g = 0; last_w3 = '0;
    while ((ng < 3 || nd < 3) && cyc < 60) begin
      @(negedge clk); cyc++;
      if (gnt3 != 3'b000) begin
        chk("sw_gnt", gnt3, 3'b001 << ng);
        if (ng > 0) chk("sw_gap", cyc - last_g, 7);
        last_g = cyc; last_w3 = gnt3; ng++;
        if (ng == 3) req3 = 3'b000;
      end
      if (ng > 0 && cyc == last_g + 1) chk("sw_rn", rn3, (val3 & last_w3) != 0);
      if (done3 != 3'b000) begin
        chk("sw_done", done3, last_w3); chk("sw_done_lat", cyc - last_g, 5); nd++;
      end
    end
    chk("sw_ngnt", ng, 3); chk("sw_ndone", nd, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
